// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file constants and decode-side control types.
package regfile_scoreboard_pkg;

    localparam int unsigned NUM_REGS       = 32;
    localparam int unsigned REG_ADDR_W     = 5;
    localparam int unsigned PEND_W_DEFAULT = 2;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SHIFT,
        ALU_PASS
    } alu_op_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest_reg;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  alu_src;
        alu_op_e               alu_op;
    } control_signals_struct;

endpackage

// File: rtl/regfile_scoreboard_reg_scoreboard.sv
// Per-register pending-write counters, sticky underflow flag and issue-ready logic.
module reg_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned PEND_W = PEND_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic                  rd_used,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  rs1_used,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  retire_valid,
    input  logic [REG_ADDR_W-1:0] retire_reg,
    output logic                  issue_ready,
    output logic                  sb_error
);

    logic [PEND_W-1:0] pend_q [NUM_REGS];
    logic [PEND_W-1:0] pend_d [NUM_REGS];
    logic              sb_error_q;
    logic              sb_error_d;

    logic issue;
    logic retire;
    logic same_reg;
    logic rs1_ready;
    logic rs2_ready;
    logic rd_block;

    // A source waiting on exactly one write is released when that write retires now.
    always_comb begin
        retire    = retire_valid && (retire_reg != '0);
        rs1_ready = !rs1_used || (rs1_addr == '0) || (pend_q[rs1_addr] == '0) ||
                    ((pend_q[rs1_addr] == PEND_W'(1)) && retire && (retire_reg == rs1_addr));
        rs2_ready = !rs2_used || (rs2_addr == '0) || (pend_q[rs2_addr] == '0) ||
                    ((pend_q[rs2_addr] == PEND_W'(1)) && retire && (retire_reg == rs2_addr));
        rd_block  = rd_used && (rd_addr != '0) && (pend_q[rd_addr] == '1);
        issue_ready = reset || (rs1_ready && rs2_ready && !rd_block);
        issue       = issue_valid && issue_ready && rd_used && (rd_addr != '0);
        same_reg    = issue && retire && (rd_addr == retire_reg);
    end

    always_comb begin
        pend_d     = pend_q;
        sb_error_d = sb_error_q;
        if (issue && !same_reg) begin
            pend_d[rd_addr] = pend_q[rd_addr] + PEND_W'(1);
        end
        if (retire) begin
            if (pend_q[retire_reg] == '0) begin
                sb_error_d = 1'b1;
            end else if (!same_reg) begin
                pend_d[retire_reg] = pend_q[retire_reg] - PEND_W'(1);
            end
        end
        pend_d[0] = '0;
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                pend_d[r] = '0;
            end
            sb_error_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        pend_q     <= pend_d;
        sb_error_q <= sb_error_d;
    end

    assign sb_error = sb_error_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through bypass and pending-write hazard scoreboard.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned PEND_W = PEND_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_write_enable,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic [XLEN-1:0]       wb_write_data,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  rd_used,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  sb_error
);

    logic [XLEN-1:0] mem_q [NUM_REGS];
    logic [XLEN-1:0] mem_d [NUM_REGS];
    logic            wr_hit;

    assign wr_hit = wb_write_enable && (wb_write_reg != '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_hit) begin
            mem_d[wb_write_reg] = wb_write_data;
        end
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                mem_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (!reset && (rs1_addr != '0)) begin
            rs1_data = (wr_hit && (wb_write_reg == rs1_addr)) ? wb_write_data : mem_q[rs1_addr];
        end
        if (!reset && (rs2_addr != '0)) begin
            rs2_data = (wr_hit && (wb_write_reg == rs2_addr)) ? wb_write_data : mem_q[rs2_addr];
        end
    end

    reg_scoreboard #(
        .PEND_W(PEND_W)
    ) u_reg_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .rd_used      (rd_used),
        .rd_addr      (rd_addr),
        .rs1_used     (rs1_used),
        .rs1_addr     (rs1_addr),
        .rs2_used     (rs2_used),
        .rs2_addr     (rs2_addr),
        .retire_valid (wb_write_enable),
        .retire_reg   (wb_write_reg),
        .issue_ready  (issue_ready),
        .sb_error     (sb_error)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_write_enable;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_used;
    logic        rs2_used;
    logic [4:0]  rd_addr;
    logic        rd_used;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        sb_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .XLEN   (32),
        .PEND_W (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wb_write_enable (wb_write_enable),
        .wb_write_reg    (wb_write_reg),
        .wb_write_data   (wb_write_data),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_used        (rs1_used),
        .rs2_used        (rs2_used),
        .rd_addr         (rd_addr),
        .rd_used         (rd_used),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .sb_error        (sb_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then return all inputs to idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        wb_write_enable = 1'b0;
        wb_write_reg    = '0;
        wb_write_data   = '0;
        rs1_addr = '0; rs1_used = 1'b0;
        rs2_addr = '0; rs2_used = 1'b0;
        rd_addr  = '0; rd_used  = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        issue_valid = 1'b1; rd_used = 1'b1; rd_addr = rd;
    endtask

    task automatic read_src(input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2);
        rs1_addr = a1; rs1_used = u1;
        rs2_addr = a2; rs2_used = u2;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_write_enable = 1'b1; wb_write_reg = r; wb_write_data = d;
    endtask

    initial begin
        reset = 1'b1;
        next_cycle();
        reset = 1'b1;
        wb(5'd5, 32'h5555_5555);
        issue_rd(5'd1);
        read_src(5'd5, 1'b1, 5'd0, 1'b0);
        settle();
        check("reset_ready", {31'd0, issue_ready}, 32'd1);
        check("reset_rs1_zero", rs1_data, 32'd0);
        next_cycle();
        reset = 1'b0;

        // Post-reset state; write and issue in the reset cycle were dropped
        read_src(5'd5, 1'b1, 5'd0, 1'b1);
        settle();
        check("init_x5", rs1_data, 32'd0);
        check("init_x0", rs2_data, 32'd0);
        check("init_ready", {31'd0, issue_ready}, 32'd1);
        check("init_sb_error", {31'd0, sb_error}, 32'd0);
        read_src(5'd1, 1'b1, 5'd0, 1'b0);
        issue_rd(5'd1);
        settle();
        check("init_x1_not_pending", {31'd0, issue_ready}, 32'd1);
        issue_valid = 1'b0;

        // RAW on x3 with bypass on the write-back cycle
        next_cycle();
        issue_rd(5'd3);
        settle();
        check("x3_issue_ready", {31'd0, issue_ready}, 32'd1);
        next_cycle();
        issue_valid = 1'b1;
        read_src(5'd3, 1'b1, 5'd0, 1'b0);
        settle();
        check("x3_raw_stall", {31'd0, issue_ready}, 32'd0);
        next_cycle();
        issue_valid = 1'b1;
        read_src(5'd3, 1'b1, 5'd0, 1'b0);
        wb(5'd3, 32'hDEAD_BEEF);
        settle();
        check("x3_wb_ready", {31'd0, issue_ready}, 32'd1);
        check("x3_bypass", rs1_data, 32'hDEAD_BEEF);
        next_cycle();
        read_src(5'd0, 1'b0, 5'd3, 1'b1);
        settle();
        check("x3_array", rs2_data, 32'hDEAD_BEEF);
        check("x3_clear_ready", {31'd0, issue_ready}, 32'd1);

        // WAW saturation on x7
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            issue_rd(5'd7);
            settle();
            check($sformatf("x7_issue%0d", i), {31'd0, issue_ready}, 32'd1);
        end
        next_cycle();
        issue_rd(5'd7);
        settle();
        check("x7_fourth_blocked", {31'd0, issue_ready}, 32'd0);
        next_cycle();
        wb(5'd7, 32'h0000_0077);
        issue_rd(5'd7);
        settle();
        check("x7_blocked_during_wb", {31'd0, issue_ready}, 32'd0);
        next_cycle();
        issue_rd(5'd7);
        settle();
        check("x7_fourth_accepted", {31'd0, issue_ready}, 32'd1);
        next_cycle();
        issue_rd(5'd7);
        settle();
        check("x7_full_again", {31'd0, issue_ready}, 32'd0);
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            wb(5'd7, 32'h0000_0070 + i);
        end
        next_cycle();
        read_src(5'd7, 1'b1, 5'd0, 1'b0);
        settle();
        check("x7_drained", {31'd0, issue_ready}, 32'd1);
        check("x7_last_value", rs1_data, 32'h0000_0072);
        check("x7_no_error", {31'd0, sb_error}, 32'd0);

        // Same-cycle issue and retire on x9
        next_cycle();
        issue_rd(5'd9);
        next_cycle();
        issue_rd(5'd9);
        wb(5'd9, 32'h0000_0099);
        settle();
        check("x9_issue_with_wb", {31'd0, issue_ready}, 32'd1);
        next_cycle();
        issue_valid = 1'b1;
        read_src(5'd9, 1'b1, 5'd0, 1'b0);
        settle();
        check("x9_rs1_stall", {31'd0, issue_ready}, 32'd0);
        read_src(5'd0, 1'b0, 5'd9, 1'b1);
        settle();
        check("x9_rs2_stall", {31'd0, issue_ready}, 32'd0);
        read_src(5'd9, 1'b0, 5'd9, 1'b0);
        settle();
        check("x9_unused_src_ok", {31'd0, issue_ready}, 32'd1);
        read_src(5'd9, 1'b1, 5'd0, 1'b0);
        wb(5'd9, 32'h0000_9999);
        settle();
        check("x9_release_ready", {31'd0, issue_ready}, 32'd1);
        check("x9_release_bypass", rs1_data, 32'h0000_9999);
        check("x9_no_error", {31'd0, sb_error}, 32'd0);

        // Unmatched write-back sets the sticky error; x0 stays zero
        next_cycle();
        wb(5'd4, 32'h0000_1234);
        next_cycle();
        read_src(5'd4, 1'b1, 5'd0, 1'b0);
        settle();
        check("x4_sb_error", {31'd0, sb_error}, 32'd1);
        check("x4_value", rs1_data, 32'h0000_1234);
        next_cycle();
        wb(5'd0, 32'h0000_FFFF);
        read_src(5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        check("x0_no_bypass", rs1_data, 32'd0);
        next_cycle();
        read_src(5'd0, 1'b1, 5'd4, 1'b1);
        settle();
        check("x0_after_write", rs1_data, 32'd0);
        check("sb_error_sticky", {31'd0, sb_error}, 32'd1);

        // Reset mid-flight
        next_cycle();
        issue_rd(5'd2);
        next_cycle();
        issue_rd(5'd6);
        next_cycle();
        issue_valid = 1'b1;
        read_src(5'd2, 1'b1, 5'd6, 1'b1);
        settle();
        check("x2_pending_stall", {31'd0, issue_ready}, 32'd0);
        reset = 1'b1;
        wb(5'd5, 32'h0000_AAAA);
        settle();
        check("midreset_ready", {31'd0, issue_ready}, 32'd1);
        check("midreset_rs1_zero", rs1_data, 32'd0);
        next_cycle();
        reset = 1'b0;
        issue_valid = 1'b1;
        read_src(5'd2, 1'b1, 5'd6, 1'b1);
        settle();
        check("postreset_ready", {31'd0, issue_ready}, 32'd1);
        check("postreset_x2", rs1_data, 32'd0);
        check("postreset_sb_error", {31'd0, sb_error}, 32'd0);
        read_src(5'd3, 1'b1, 5'd5, 1'b1);
        issue_valid = 1'b0;
        settle();
        check("postreset_x3", rs1_data, 32'd0);
        check("postreset_x5", rs2_data, 32'd0);

        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Integer register file plus per-register pending-write scoreboard, sitting between decode and write-back. It accepts the write-back stage's single write port (`write_data`/`write_reg`/`write_enable`), serves two combinational read ports to decode with same-cycle write-through bypass, and tracks outstanding writes per register. Decode uses `issue_ready` as its RAW/WAW hazard stall.

## Interface
- `XLEN`, 32: register and data width; matches the write-back data width.
- `PEND_W`, 2: pending-counter width; allows up to 3 outstanding writes per register.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `wb_write_enable`  in  1  write-back stage write strobe.
- `wb_write_reg`  in  5  destination register.
- `wb_write_data`  in  XLEN  write value.
- `rs1_addr`, `rs2_addr`  in  5 each  decode source addresses.
- `rs1_used`, `rs2_used`  in  1 each  source actually read by the instruction.
- `rd_addr`  in  5  decode destination.
- `rd_used`  in  1  instruction writes a register (loads, ALU, LUI, AUIPC).
- `issue_valid`  in  1  decode presents an instruction.
- `issue_ready`  out  1  no hazard; instruction may issue this cycle.
- `rs1_data`, `rs2_data`  out  XLEN  source operands.
- `sb_error`  out  1  sticky; write-back arrived for a register with no pending write.

## Operation
- Array: 32 x XLEN. x0 always reads 0. Writes to x0 are discarded and never touch counters.
- Write: when `wb_write_enable` is high and `wb_write_reg` != 0, array[reg] <= data at the clock edge.
- Read: `rsN_data` = 0 if addr = 0. Otherwise it is the bypassed `wb_write_data` if a write to the same address occurs this cycle. Otherwise it is array[addr].
- Scoreboard: `pend[r]`, PEND_W bits, r = 1..31.
  - `issue` = `issue_valid` & `issue_ready` & `rd_used` & `rd_addr` != 0, and increments `pend[rd_addr]`.
  - `retire` = `wb_write_enable` & `wb_write_reg` != 0, and decrements `pend[wb_write_reg]`.
  - Issue and retire to the same register in one cycle: net unchanged.
  - Retire with `pend` = 0: counter stays 0 and `sb_error` <= 1 until reset. The array write still occurs.
- Source ready rule: source N is ready if `rsN_used` = 0, or addr = 0, or `pend[addr]` = 0.
  - A source is also ready if `pend[addr]` = 1 and a retire to that address occurs this cycle (covered by the bypass).
- `issue_ready` = rs1 ready & rs2 ready & !(`rd_used` & `rd_addr` != 0 & `pend[rd_addr]` = max (3)).
  - It is combinational and independent of `issue_valid`.
- Decode holds its inputs stable while `issue_valid` & !`issue_ready`.

## Timing
- Reset: array all 0, all `pend` 0, `sb_error` 0.
  - During reset, `issue_ready` = 1 and read data = 0.
  - Writes and issues presented in the reset cycle are ignored.
- Write to visible-in-array latency is 1 cycle. Operand visibility is 0 cycles through the bypass.
- Counter updates land at the edge. `issue_ready` reflects post-update counters in the next cycle.
- Reset mid-operation clears all pending state. The upstream pipeline is reset in the same cycle.
- Saturation: `pend` never exceeds 3, because `issue_ready` blocks a 4th issue. `pend` never goes below 0.

## Structure
- Shared package:
  - `NUM_REGS` = 32 and `REG_ADDR_W` = 5.
  - Default `PEND_W`.
  - Existing `control_signals_struct`, whose `dest_reg` drives `rd_addr`.
- One sub-module, `reg_scoreboard`, holds the pending counters, the `sb_error` flag and the ready logic. The top holds the array and the bypass.

## Test plan
- Reset, then read x5/x0 -> both 0. `issue_ready` = 1. `sb_error` = 0.
- Issue rd = x3, then write-back x3 = 0xDEADBEEF two cycles later. Meanwhile an instruction reading x3 gets `issue_ready` = 0. In the write-back cycle, `issue_ready` = 1 and `rs1_data` = 0xDEADBEEF (bypass). Next cycle the array read gives the same value.
- Issue rd = x7 three times -> fourth issue with rd = x7 sees `issue_ready` = 0. After one write-back to x7, the fourth issue is accepted.
- Issue and write-back to x9 in the same cycle, with `pend[x9]` = 1 beforehand -> `pend[x9]` stays 1 and a reader of x9 stalls.
- Write-back x4 = 0x1234 with `pend[x4]` = 0 -> `sb_error` = 1 and stays high, x4 reads 0x1234. A write-back to x0 with data 0xFFFF leaves x0 reading 0.
- Issue x2 and x6, then assert reset mid-flight -> next cycle all counters are 0, `issue_ready` = 1, x2 reads 0.
